pio_host_arbiter: RTL and testbench

//  Shares the single PIO host command port (action/mindex/index/din -> dout) between

---
 rtl/pio_host_arbiter_if.sv | 30 +++
 rtl/pio_host_arbiter.sv | 122 ++++++++++++
 tb/tb_pio_host_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_host_arbiter_if.sv
// Requester/PIO bundle for the shared PIO host command port.
// The arbiter takes the slave side; requesters plus the PIO block take the master side.
interface pio_host_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_lock;
    logic [4*NREQ-1:0]  req_action;
    logic [2*NREQ-1:0]  req_mindex;
    logic [5*NREQ-1:0]  req_index;
    logic [32*NREQ-1:0] req_din;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic [3:0]         pio_action;
    logic [1:0]         pio_mindex;
    logic [4:0]         pio_index;
    logic [31:0]        pio_din;
    logic [31:0]        pio_dout;

    modport slave (
        input  req_valid, req_lock, req_action, req_mindex, req_index, req_din, pio_dout,
        output req_ready, rsp_valid, rsp_data, pio_action, pio_mindex, pio_index, pio_din
    );

    modport master (
        output req_valid, req_lock, req_action, req_mindex, req_index, req_din, pio_dout,
        input  req_ready, rsp_valid, rsp_data, pio_action, pio_mindex, pio_index, pio_din
    );
endinterface

// File: rtl/pio_host_arbiter.sv
// Round-robin/lockable arbiter sharing one PIO host command port among NREQ requesters.
// Latency: grant same cycle, pio_* one cycle after accept, read response two cycles after accept.
// Backpressure: req_ready is the combinational grant; non-granted requesters simply hold.
module pio_host_arbiter #(
    parameter int NREQ     = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic               clk,
    input  logic               reset,
    pio_host_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(LOCK_MAX + 1);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] lock_owner;
    logic           lock_vld;
    logic [CW-1:0]  idle_cnt;

    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW-1:0] scan_id;
    int             scan_idx;

    logic [3:0]     gnt_action;
    logic [1:0]     gnt_mindex;
    logic [4:0]     gnt_index;
    logic [31:0]    gnt_din;

    logic [3:0]     pio_action_q;
    logic [1:0]     pio_mindex_q;
    logic [4:0]     pio_index_q;
    logic [31:0]    pio_din_q;

    logic           s1_vld;
    logic [IDW-1:0] s1_id;
    logic [NREQ-1:0] rsp_vec;

    // Scan downward so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = 0;
        scan_id  = '0;
        if (lock_vld) begin
            gnt_vld = bus.req_valid[lock_owner];
            gnt_id  = lock_owner;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scan_idx = (int'(rr_ptr) + k) % NREQ;
                scan_id  = IDW'(scan_idx);
                if (bus.req_valid[scan_id]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan_id;
                end
            end
        end
    end

    assign nxt_ptr    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    assign gnt_action = bus.req_action[4*gnt_id +: 4];
    assign gnt_mindex = bus.req_mindex[2*gnt_id +: 2];
    assign gnt_index  = bus.req_index[5*gnt_id +: 5];
    assign gnt_din    = bus.req_din[32*gnt_id +: 32];

    assign bus.req_ready  = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    assign bus.rsp_valid  = rsp_vec;
    assign bus.rsp_data   = bus.pio_dout;
    assign bus.pio_action = pio_action_q;
    assign bus.pio_mindex = pio_mindex_q;
    assign bus.pio_index  = pio_index_q;
    assign bus.pio_din    = pio_din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            lock_owner   <= '0;
            lock_vld     <= 1'b0;
            idle_cnt     <= '0;
            pio_action_q <= 4'd0;
            pio_mindex_q <= 2'd0;
            pio_index_q  <= 5'd0;
            pio_din_q    <= 32'd0;
            s1_vld       <= 1'b0;
            s1_id        <= '0;
            rsp_vec      <= '0;
        end else begin
            // Idle cycles issue a PIO no-op; the other fields keep their last value.
            pio_action_q <= 4'd0;
            if (gnt_vld) begin
                rr_ptr       <= nxt_ptr;
                pio_action_q <= gnt_action;
                pio_mindex_q <= gnt_mindex;
                pio_index_q  <= gnt_index;
                pio_din_q    <= gnt_din;
            end

            // PIO registers dout one cycle after the command, so the id rides two stages.
            s1_vld  <= gnt_vld && (gnt_action == 4'd3);
            s1_id   <= gnt_id;
            rsp_vec <= s1_vld ? (NREQ'(1) << s1_id) : '0;

            // While locked only the owner can be granted, so a locked grant is an owner accept.
            if (gnt_vld && bus.req_lock[gnt_id]) begin
                lock_vld   <= 1'b1;
                lock_owner <= gnt_id;
                idle_cnt   <= '0;
            end else if (gnt_vld && lock_vld) begin
                lock_vld <= 1'b0;
                idle_cnt <= '0;
            end else if (lock_vld && !bus.req_valid[lock_owner]) begin
                if (idle_cnt == CW'(LOCK_MAX - 1)) begin
                    lock_vld <= 1'b0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pio_host_arbiter.sv
// Scoreboard bench for pio_host_arbiter: tasks push expected PIO commands/read responses,
// a negedge monitor pops and compares them; grants are checked inline per scenario.
module tb_pio_host_arbiter;
    localparam int NREQ     = 2;
    localparam int LOCK_MAX = 64;

    typedef struct {
        int          due;
        logic [3:0]  act;
        logic [1:0]  mi;
        logic [4:0]  ix;
        logic [31:0] din;
    } cmd_t;

    typedef struct {
        int              due;
        logic [NREQ-1:0] vec;
        logic [31:0]     data;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    logic [NREQ-1:0]    tb_valid  = '0;
    logic [NREQ-1:0]    tb_lock   = '0;
    logic [4*NREQ-1:0]  tb_action = '0;
    logic [2*NREQ-1:0]  tb_mindex = '0;
    logic [5*NREQ-1:0]  tb_index  = '0;
    logic [32*NREQ-1:0] tb_din    = '0;
    logic [31:0]        pio_dout_m;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t mc;
    rsp_t mr;

    pio_host_arbiter_if #(.NREQ(NREQ)) bus ();

    pio_host_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.req_valid  = tb_valid;
    assign bus.req_lock   = tb_lock;
    assign bus.req_action = tb_action;
    assign bus.req_mindex = tb_mindex;
    assign bus.req_index  = tb_index;
    assign bus.req_din    = tb_din;
    assign bus.pio_dout   = pio_dout_m;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO model: a read returns din ^ 0xDEADBEEF, registered on the edge ending the command cycle.
    always @(posedge clk or posedge reset) begin
        if (reset)
            pio_dout_m <= 32'd0;
        else if (bus.pio_action == 4'd3)
            pio_dout_m <= bus.pio_din ^ 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                mc = cmd_q.pop_front();
                if (bus.pio_action !== mc.act || bus.pio_mindex !== mc.mi ||
                    bus.pio_index !== mc.ix || bus.pio_din !== mc.din) begin
                    errors++;
                    $display("FAIL pio_cmd cyc=%0d got act=%0h mi=%0d ix=%0d din=%h want act=%0h mi=%0d ix=%0d din=%h",
                             cyc, bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din,
                             mc.act, mc.mi, mc.ix, mc.din);
                end
            end else if (bus.pio_action !== 4'd0) begin
                errors++;
                $display("FAIL pio_idle cyc=%0d got act=%0h want 0", cyc, bus.pio_action);
            end
            checks++;
            if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
                mr = rsp_q.pop_front();
                if (bus.rsp_valid !== mr.vec || bus.rsp_data !== mr.data) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got vld=%b data=%h want vld=%b data=%h",
                             cyc, bus.rsp_valid, bus.rsp_data, mr.vec, mr.data);
                end
            end else if (bus.rsp_valid !== '0) begin
                errors++;
                $display("FAIL rsp_idle cyc=%0d got vld=%b want 0", cyc, bus.rsp_valid);
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic lk, input logic [3:0] a,
                           input logic [1:0] m, input logic [4:0] ix, input logic [31:0] d);
        tb_valid[id]          = v;
        tb_lock[id]           = lk;
        tb_action[4*id +: 4]  = a;
        tb_mindex[2*id +: 2]  = m;
        tb_index[5*id +: 5]   = ix;
        tb_din[32*id +: 32]   = d;
    endtask

    task automatic clear_reqs();
        tb_valid = '0;
        tb_lock  = '0;
    endtask

    task automatic push_cmd(input int due, input logic [3:0] a, input logic [1:0] m,
                            input logic [4:0] ix, input logic [31:0] d);
        cmd_t c;
        c.due = due; c.act = a; c.mi = m; c.ix = ix; c.din = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input int due, input int id, input logic [31:0] d);
        rsp_t r;
        r.due  = due;
        r.vec  = NREQ'(1) << id;
        r.data = d ^ 32'hDEADBEEF;
        rsp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            clear_reqs();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        cmd_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.pio_action !== 4'd0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got rdy=%b rsp=%b act=%0h want 0/0/0",
                         k, bus.req_ready, bus.rsp_valid, bus.pio_action);
            end
        end
    endtask

    task automatic test_rotation();
        logic [NREQ-1:0] exp;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b0, 4'd1, 2'd0, 5'd0, 32'hA);
            set_req(1, 1'b1, 1'b0, 4'd1, 2'd0, 5'd0, 32'hB);
            #1;
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.req_ready !== exp) begin
                errors++;
                $display("FAIL rotation_ready k=%0d got %b want %b", k, bus.req_ready, exp);
            end
            push_cmd(cyc + 1, 4'd1, 2'd0, 5'd0, (k % 2 == 0) ? 32'hA : 32'hB);
        end
        idle(3);
    endtask

    task automatic test_read();
        logic [NREQ-1:0] exp;
        do_reset();
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 4'd3, 2'd2, 5'd5, 32'h0);
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL read_ready got %b want 10", bus.req_ready);
        end
        push_cmd(cyc + 1, 4'd3, 2'd2, 5'd5, 32'h0);
        push_rsp(cyc + 2, 1, 32'h0);
        idle(4);
        // Back-to-back reads alternating requesters return in issue order.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b0, 4'd3, 2'd1, 5'd3, 32'h1000 + k);
            set_req(1, 1'b1, 1'b0, 4'd3, 2'd3, 5'd7, 32'h2000 + k);
            #1;
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.req_ready !== exp) begin
                errors++;
                $display("FAIL read_mix_ready k=%0d got %b want %b", k, bus.req_ready, exp);
            end
            if (k % 2 == 0) begin
                push_cmd(cyc + 1, 4'd3, 2'd1, 5'd3, 32'h1000 + k);
                push_rsp(cyc + 2, 0, 32'h1000 + k);
            end else begin
                push_cmd(cyc + 1, 4'd3, 2'd3, 5'd7, 32'h2000 + k);
                push_rsp(cyc + 2, 1, 32'h2000 + k);
            end
        end
        idle(4);
    endtask

    task automatic test_actions();
        logic [3:0]  acts [5] = '{4'd0, 4'd15, 4'd3, 4'd7, 4'd3};
        logic [1:0]  mis  [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [4:0]  ixs  [5] = '{5'd0, 5'd31, 5'd9, 5'd17, 5'd4};
        logic [31:0] dins [5] = '{32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0F0F_0F0F, 32'hCAFE_F00D};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_req(0, 1'b1, 1'b0, acts[k], mis[k], ixs[k], dins[k]);
            #1;
            checks++;
            if (bus.req_ready !== 2'b01) begin
                errors++;
                $display("FAIL action_ready k=%0d got %b want 01", k, bus.req_ready);
            end
            push_cmd(cyc + 1, acts[k], mis[k], ixs[k], dins[k]);
            if (acts[k] == 4'd3) push_rsp(cyc + 2, 0, dins[k]);
        end
        idle(3);
        #1;
        checks++;
        if (bus.pio_din !== 32'hCAFE_F00D || bus.pio_index !== 5'd4 || bus.pio_mindex !== 2'd3) begin
            errors++;
            $display("FAIL hold_fields got din=%h ix=%0d mi=%0d want din=cafef00d ix=4 mi=3",
                     bus.pio_din, bus.pio_index, bus.pio_mindex);
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] exp_rdy [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        logic v0 [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic l0 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic l1 [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            set_req(0, v0[k], l0[k], 4'd1, 2'd0, 5'd0, 32'h100 + k);
            set_req(1, 1'b1, l1[k], 4'd2, 2'd1, 5'd3, 32'h200 + k);
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy[k]) begin
                errors++;
                $display("FAIL lock_ready k=%0d got %b want %b", k, bus.req_ready, exp_rdy[k]);
            end
            if (exp_rdy[k] == 2'b01) push_cmd(cyc + 1, 4'd1, 2'd0, 5'd0, 32'h100 + k);
            else                     push_cmd(cyc + 1, 4'd2, 2'd1, 5'd3, 32'h200 + k);
        end
        idle(3);
    endtask

    task automatic test_lock_timeout();
        logic [NREQ-1:0] exp;
        do_reset();
        for (int k = 0; k < 98; k++) begin
            @(negedge clk);
            if (k == 0 || k == 31) set_req(0, 1'b1, 1'b1, 4'd1, 2'd0, 5'd1, 32'h300 + k);
            else                   set_req(0, 1'b0, 1'b0, 4'd1, 2'd0, 5'd1, 32'h300 + k);
            set_req(1, (k >= 1 && k <= 96), 1'b0, 4'd2, 2'd2, 5'd2, 32'h400);
            #1;
            if (k == 0 || k == 31) exp = 2'b01;
            else if (k == 96)      exp = 2'b10;
            else                   exp = 2'b00;
            checks++;
            if (bus.req_ready !== exp) begin
                errors++;
                $display("FAIL lock_timeout_ready k=%0d got %b want %b", k, bus.req_ready, exp);
            end
            if (exp == 2'b01) push_cmd(cyc + 1, 4'd1, 2'd0, 5'd1, 32'h300 + k);
            if (exp == 2'b10) push_cmd(cyc + 1, 4'd2, 2'd2, 5'd2, 32'h400);
        end
        idle(3);
    endtask

    task automatic test_reset_midread();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd3, 2'd1, 5'd7, 32'h1234);
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midread_ready got %b want 01", bus.req_ready);
        end
        push_cmd(cyc + 1, 4'd3, 2'd1, 5'd7, 32'h1234);
        push_rsp(cyc + 2, 0, 32'h1234);
        @(negedge clk);
        clear_reqs();
        #2 reset = 1'b1;
        rsp_q.delete();
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== '0 || bus.pio_action !== 4'd0) begin
            errors++;
            $display("FAIL midread_drop got rsp=%b act=%0h want 0/0", bus.rsp_valid, bus.pio_action);
        end
        #2 reset = 1'b0;
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_read();
        test_actions();
        test_lock();
        test_lock_timeout();
        test_reset_midread();
        @(negedge clk);
        checks++;
        if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got cmd=%0d rsp=%0d want 0/0", cmd_q.size(), rsp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
